// File: rtl/clint_timer_pkg.sv
// Shared register map, reset constants and request record for the core-local interruptor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ClintStruct;

   localparam logic [15:0] MSIP_OFF     = 16'h0000;
   localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } ClintReq;

   // Registers are 8-byte aligned; the low three address bits never select anything.
   function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] off);
      return (addr & 16'hFFF8) == off;
   endfunction

   function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  wmask);
      logic [63:0] res;
      res = cur;
      for (int b = 0; b < 8; b++) begin
         if (wmask[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Request/response port between the MEM-stage decoder (master) and the CLINT (slave).
// Latency: n/a (wiring only).
// Backpressure: req_ready / resp_ready valid-ready handshakes.
interface clint_timer_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

// File: rtl/clint_timer_tick_gen.sv
// Prescaler for mtime: pulses tick once every PRESCALE core clocks (every cycle when PRESCALE=1).
// Latency: tick is combinational from the count register.
// Backpressure: none; free-running.
module clint_tick_gen #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [15:0] TERM = 16'(PRESCALE - 1);

   logic [15:0] cnt;

   assign tick = (cnt == TERM);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime, mtimecmp and optional msip (CLINT_MSIP_EN) on a req/resp port.
// Latency: response one cycle after acceptance; time_int one cycle after the mtime/mtimecmp update.
// Backpressure: req_ready = ~resp_valid | resp_ready; one response in flight, held until consumed.
module clint_timer
   import ClintStruct::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic          clk,
   input  logic          rst,
   clint_timer_if.slave  bus,
   output logic          time_int,
   output logic          soft_int
);

   ClintReq     req;
   logic        accept;
   logic        wr;
   logic        tick;
   logic        hit_mtime;
   logic        hit_mtimecmp;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] rd_data;
   logic        resp_valid_q;
   logic [63:0] resp_rdata_q;

   assign req = '{we:    bus.req_we,
                  addr:  bus.req_addr,
                  wdata: bus.req_wdata,
                  wmask: bus.req_wmask};

   assign bus.req_ready  = ~resp_valid_q | bus.resp_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;

   assign accept       = bus.req_valid & bus.req_ready;
   assign wr           = accept & req.we;
   assign hit_mtime    = addr_hit(req.addr, MTIME_OFF);
   assign hit_mtimecmp = addr_hit(req.addr, MTIMECMP_OFF);

   clint_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

`ifdef CLINT_MSIP_EN
   logic hit_msip;
   logic msip;

   assign hit_msip = addr_hit(req.addr, MSIP_OFF);
   assign soft_int = msip;

   always_ff @(posedge clk) begin
      if (rst) begin
         msip <= 1'b0;
      end else if (wr && hit_msip && req.wmask[0]) begin
         msip <= req.wdata[0];
      end
   end
`else
   assign soft_int = 1'b0;
`endif

   // A software write to mtime beats a coincident tick; the prescaler keeps counting regardless.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime <= '0;
      end else if (wr && hit_mtime) begin
         mtime <= merge_bytes(mtime, req.wdata, req.wmask);
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtimecmp <= MTIMECMP_RST;
      end else if (wr && hit_mtimecmp) begin
         mtimecmp <= merge_bytes(mtimecmp, req.wdata, req.wmask);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         time_int <= 1'b0;
      end else begin
         time_int <= (mtime >= mtimecmp);
      end
   end

   // Reads see register contents before any update on the accepting edge.
   always_comb begin
      rd_data = '0;
      if (hit_mtime) begin
         rd_data = mtime;
      end else if (hit_mtimecmp) begin
         rd_data = mtimecmp;
      end
`ifdef CLINT_MSIP_EN
      else if (hit_msip) begin
         rd_data = {63'd0, msip};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else if (accept) begin
         resp_valid_q <= 1'b1;
         resp_rdata_q <= req.we ? 64'd0 : rd_data;
      end else if (bus.resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: PRESCALE=1 instance for the register/handshake behaviour,
// PRESCALE=4 instance for compare timing; read data checked through an expected-value queue.
`timescale 1ns/1ps
module tb_clint_timer;
   import ClintStruct::*;

   logic clk = 1'b0;
   logic rst1;
   logic rst4;
   logic time_int1, soft_int1, time_int4, soft_int4;

   clint_timer_if bus1();
   clint_timer_if bus4();

   clint_timer #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst1), .bus(bus1), .time_int(time_int1), .soft_int(soft_int1)
   );

   clint_timer #(.PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst4), .bus(bus4), .time_int(time_int4), .soft_int(soft_int4)
   );

   always #5 clk = ~clk;

   int          n_pass  = 0;
   int          n_total = 0;
   int unsigned cyc     = 0;
   int unsigned c4      = 0;
   int unsigned t4_rise = 0;
   logic [63:0] sb_q[$];

`ifdef CLINT_MSIP_EN
   localparam logic [63:0] MSIP_EXP = 64'd1;
`else
   localparam logic [63:0] MSIP_EXP = 64'd0;
`endif

   // Edges since reset release: equals the mtime value a PRESCALE=1 read sees when driven now.
   always @(posedge clk) begin
      if (rst1) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      if (rst4) c4 <= 0;
      else      c4 <= c4 + 1;
   end

   always @(negedge clk) begin
      if (!rst4 && t4_rise == 0 && time_int4) t4_rise = c4;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // One access on dut1; returns at the falling edge right after the accepting edge.
   task automatic access1(input string tag, input logic we, input logic [15:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          input logic [63:0] exp, input bit exp_is_time);
      int waited;
      @(negedge clk);
      bus1.req_valid = 1'b1;
      bus1.req_we    = we;
      bus1.req_addr  = addr;
      bus1.req_wdata = wdata;
      bus1.req_wmask = wmask;
      if (exp_is_time) sb_q.push_back(64'(cyc));
      else             sb_q.push_back(exp);
      @(negedge clk);
      bus1.req_valid = 1'b0;
      waited = 0;
      while (!bus1.resp_valid && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, "_vld"}, 64'(bus1.resp_valid), 64'd1);
      chk(tag, bus1.resp_rdata, sb_q.pop_front());
   endtask

   initial begin
      logic [63:0] held;
      int          waited;

      rst1 = 1'b1; rst4 = 1'b1;
      bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
      bus1.req_wdata = '0;   bus1.req_wmask = '0; bus1.resp_ready = 1'b1;
      bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_addr = '0;
      bus4.req_wdata = '0;   bus4.req_wmask = '0; bus4.resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst1 = 1'b0; rst4 = 1'b0;

      chk("rst_time_int",   64'(time_int1),        64'd0);
      chk("rst_soft_int",   64'(soft_int1),        64'd0);
      chk("rst_resp_valid", 64'(bus1.resp_valid),  64'd0);
      chk("rst_resp_rdata", bus1.resp_rdata,       64'd0);
      chk("rst_req_ready",  64'(bus1.req_ready),   64'd1);
      chk("rst_time_int4",  64'(time_int4),        64'd0);

      // dut4: mtimecmp = 20, accepted on the first edge after reset.
      bus4.req_valid = 1'b1; bus4.req_we = 1'b1; bus4.req_addr = MTIMECMP_OFF;
      bus4.req_wdata = 64'd20; bus4.req_wmask = 8'hFF;
      @(negedge clk);
      bus4.req_valid = 1'b0;
      chk("p4_wr_vld",   64'(bus4.resp_valid), 64'd1);
      chk("p4_wr_rdata", bus4.resp_rdata,      64'd0);

      repeat (9) @(negedge clk);
      access1("rd_mtime", 1'b0, MTIME_OFF, '0, '0, '0, 1'b1);
      chk("time_int_idle", 64'(time_int1), 64'd0);
      access1("rd_mtimecmp_rst", 1'b0, MTIMECMP_OFF, '0, '0, MTIMECMP_RST, 1'b0);

      access1("wr_cmp_masked", 1'b1, MTIMECMP_OFF, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, 1'b0);
      access1("rd_cmp_masked", 1'b0, MTIMECMP_OFF, '0, '0, 64'hFFFF_FFFF_5566_7788, 1'b0);
      access1("wr_cmp_mask0",  1'b1, MTIMECMP_OFF, 64'd0, 8'h00, 64'd0, 1'b0);
      access1("rd_cmp_mask0",  1'b0, MTIMECMP_OFF, '0, '0, 64'hFFFF_FFFF_5566_7788, 1'b0);

      access1("wr_cmp_zero", 1'b1, MTIMECMP_OFF, 64'd0, 8'hFF, 64'd0, 1'b0);
      chk("tint_cmp0_e1", 64'(time_int1), 64'd0);
      @(negedge clk);
      chk("tint_cmp0_e2", 64'(time_int1), 64'd1);

      access1("wr_cmp_ones", 1'b1, MTIMECMP_OFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b0);
      chk("tint_ones_e1", 64'(time_int1), 64'd1);
      @(negedge clk);
      chk("tint_ones_e2", 64'(time_int1), 64'd0);

      // mtime FE -> FF -> 0: compare true only while mtime == FF.
      access1("wr_mtime_wrap", 1'b1, MTIME_OFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, 1'b0);
      chk("wrap_e1", 64'(time_int1), 64'd0);
      @(negedge clk);
      chk("wrap_e2", 64'(time_int1), 64'd0);
      @(negedge clk);
      chk("wrap_e3", 64'(time_int1), 64'd1);
      @(negedge clk);
      chk("wrap_e4", 64'(time_int1), 64'd0);

      // Stall: response held, no new request accepted.
      bus1.resp_ready = 1'b0;
      @(negedge clk);
      bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = MTIMECMP_OFF;
      sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      bus1.req_valid = 1'b0;
      held = sb_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         chk("stall_vld",   64'(bus1.resp_valid), 64'd1);
         chk("stall_rdy",   64'(bus1.req_ready),  64'd0);
         chk("stall_rdata", bus1.resp_rdata,      held);
         @(negedge clk);
      end
      bus1.resp_ready = 1'b1;
      @(negedge clk);
      chk("unstall_vld", 64'(bus1.resp_valid), 64'd0);
      chk("unstall_rdy", 64'(bus1.req_ready),  64'd1);

      // Back-to-back reads, one per cycle.
      bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = MTIMECMP_OFF;
      sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      chk("b2b_vld0", 64'(bus1.resp_valid), 64'd1);
      chk("b2b_rd0",  bus1.resp_rdata, sb_q.pop_front());
      bus1.req_addr = 16'h1230;
      sb_q.push_back(64'd0);
      @(negedge clk);
      bus1.req_valid = 1'b0;
      chk("b2b_vld1", 64'(bus1.resp_valid), 64'd1);
      chk("b2b_rd1",  bus1.resp_rdata, sb_q.pop_front());

      access1("wr_unmapped", 1'b1, 16'h2000, 64'hDEAD_BEEF, 8'hFF, 64'd0, 1'b0);
      access1("rd_unmapped", 1'b0, 16'h2000, '0, '0, 64'd0, 1'b0);

      access1("wr_msip", 1'b1, MSIP_OFF, 64'd1, 8'h01, 64'd0, 1'b0);
      chk("soft_int", 64'(soft_int1), MSIP_EXP);
      access1("rd_msip", 1'b0, MSIP_OFF, '0, '0, MSIP_EXP, 1'b0);

      waited = 0;
      while (c4 < 90 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("p4_rise_cycle", 64'(t4_rise), 64'd81);
      chk("p4_time_int",   64'(time_int4), 64'd1);
      chk("p4_soft_int",   64'(soft_int4), 64'd0);

      // Reset with a pending response and a request presented during the reset cycle.
      @(negedge clk);
      bus1.resp_ready = 1'b0;
      bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = MTIME_OFF;
      @(negedge clk);
      chk("pre_rst_vld", 64'(bus1.resp_valid), 64'd1);
      rst1 = 1'b1;
      @(negedge clk);
      chk("in_rst_vld", 64'(bus1.resp_valid), 64'd0);
      rst1 = 1'b0;
      bus1.req_valid = 1'b0;
      bus1.resp_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_vld",   64'(bus1.resp_valid), 64'd0);
      chk("post_rst_rdy",   64'(bus1.req_ready),  64'd1);
      chk("post_rst_soft",  64'(soft_int1),       64'd0);
      access1("rd_cmp_after_rst", 1'b0, MTIMECMP_OFF, '0, '0, MTIMECMP_RST, 1'b0);
      access1("rd_mtime_after_rst", 1'b0, MTIME_OFF, '0, '0, '0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
